instr_decode_queue: RTL
=======================

# instr_decode_queue

Parametrised successor to the instruction state encoder. Buffers fetched instructions in a DEPTH-entry FIFO, decoding each to its control-unit start state at enqueue. Presents {instruction, start state, unknown flag} to the control unit over a valid/ready handshake. Sits between instruction fetch (IR load) and the microcoded control unit. Unknown opcodes are either dropped and counted (skip mode) or delivered with a trap state (trap mode).

## Interface
Parameters:
- STATE_W, 7: width of the state code; must be ≥7; table codes are zero-extended.
- DEPTH, 4: FIFO entries; power of two, ≥2.
- TRAP_ON_UNKNOWN, 0: 0 = skip mode (drop and count); 1 = trap mode (enqueue with TRAP_STATE).
- TRAP_STATE, 63: state code delivered for unknown instructions in trap mode.

Ports:
- clk  in  1  single clock; all state on rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- in_valid  in  1  fetch offers in_instr.
- in_ready  out  1  queue can accept; equals (count < DEPTH).
- in_instr  in  32  fetched instruction word.
- flush  in  1  synchronous queue clear (branch taken, exception).
- out_valid  out  1  head entry valid; equals (count != 0).
- out_ready  in  1  control unit consumes head.
- out_state  out  STATE_W  start state of head entry.
- out_instr  out  32  head instruction word.
- out_unknown  out  1  head entry was unknown (trap mode only).
- count  out  $clog2(DEPTH+1)  occupancy.
- unknown_count  out  16  saturating count of unknown instructions accepted.

## Operation
- Decode (combinational, first match wins, in order): ADDU 6, SUBU 17, ADDIU 18, MULTU (bits 15:6 zero) 49, SLTU 19, SLTIU 20, CLO 21, CLZ 22, AND 23, ANDI 24, OR 25, ORI 26, XOR 27, XORI 28, NOR 29, LUI 30, SLL 31, SRA 32, SRL 33, MOVN 34, MOVZ 35, MFHI 45, MFLO 46, MTHI 47, MTLO 48, SB/SH/SW 7, SD (op 111111) 50, BEQ 11, BGEZ (rt=00001) 37, BGTZ (rt=0) 39, BLEZ (rt=0) 42, BNE 41, JR (bits 20:11 zero) 44, LW/LH/LHU/LB/LBU 13. Anything else is unknown.
- Accept = in_valid && in_ready. A known instruction is written with unknown=0.
- Unknown instruction, skip mode: accepted (handshake completes), not written; unknown_count increments.
- Unknown instruction, trap mode: written with state TRAP_STATE and unknown=1; unknown_count increments.
- Pop = out_valid && out_ready; head pointer advances.
- When out_valid=0, out_state, out_instr and out_unknown read 0.
- Pointers wrap modulo DEPTH. count tracks push − pop; push and pop in the same cycle leave count unchanged.

## Timing
- Reset: count=0, pointers=0, unknown_count=0, out_valid=0, in_ready=1, all data outputs 0.
- Latency: an instruction accepted at edge N appears at the head no earlier than after edge N (empty queue: out_valid=1 in cycle N+1). No combinational path from in_* to out_*.
- Full: in_ready=0 even if a pop occurs in the same cycle (no pass-through).
- Empty: out_valid=0; a simultaneous push and pop on an empty queue is impossible by construction.
- flush: at the next edge, count and pointers are set to 0. Flush overrides push and pop in that cycle: the offered instruction is dropped and the unknown_count increment is suppressed. unknown_count itself is not cleared.
- unknown_count saturates at 16'hFFFF.
- Reset asserted mid-transfer: the queue empties asynchronously and no handshake completes in that cycle.

## Structure
- Shared package holds: state code localparams (ST_ADDU=6 … ST_SD=50, ST_SKIP=1), and opcode/funct field constants.
- One sub-module, state_decode: pure combinational 32-bit instruction → {STATE_W state, unknown}, replacing the old fixed-width encoder. The FIFO and counters live in the top level.

## Test plan
- Reset then push ADDU 0x00851021 with out_ready=0 → next cycle out_valid=1, out_state=6, out_instr=0x00851021, out_unknown=0, count=1.
- Push LW 0x8C820004, SD 0xFC000000, BNE 0x14400003, JR 0x03E00008 back to back (DEPTH=4) → in_ready=0 after the 4th push; then pop states in order 13, 50, 41, 44.
- Skip mode, push J 0x08000000 → out_valid remains 0, unknown_count=1. Trap mode, same push → out_state=63, out_unknown=1.
- Full queue with push and pop asserted together → pop occurs, push is refused, count=3. Half-full queue with push and pop together → count unchanged and order preserved across pointer wrap.
- Two entries queued, flush asserted together with in_valid (unknown instruction) → next cycle count=0, out_valid=0, unknown_count unchanged.
- Force unknown_count to 0xFFFF via 65535 unknown pushes, then one more → stays 0xFFFF. Assert reset mid-stream → all outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/instr_decode_queue_pkg.sv
// Shared constants for the instruction decode queue: control-unit start
// state codes and MIPS opcode/funct field values used by the decoder.
package instr_decode_queue_pkg;

    // Width of the native state table; wider STATE_W zero-extends these.
    localparam int CODE_W = 7;

    // Control-unit start states
    localparam logic [CODE_W-1:0] ST_SKIP  = 7'd1;
    localparam logic [CODE_W-1:0] ST_ADDU  = 7'd6;
    localparam logic [CODE_W-1:0] ST_STORE = 7'd7;
    localparam logic [CODE_W-1:0] ST_BEQ   = 7'd11;
    localparam logic [CODE_W-1:0] ST_LOAD  = 7'd13;
    localparam logic [CODE_W-1:0] ST_SUBU  = 7'd17;
    localparam logic [CODE_W-1:0] ST_ADDIU = 7'd18;
    localparam logic [CODE_W-1:0] ST_SLTU  = 7'd19;
    localparam logic [CODE_W-1:0] ST_SLTIU = 7'd20;
    localparam logic [CODE_W-1:0] ST_CLO   = 7'd21;
    localparam logic [CODE_W-1:0] ST_CLZ   = 7'd22;
    localparam logic [CODE_W-1:0] ST_AND   = 7'd23;
    localparam logic [CODE_W-1:0] ST_ANDI  = 7'd24;
    localparam logic [CODE_W-1:0] ST_OR    = 7'd25;
    localparam logic [CODE_W-1:0] ST_ORI   = 7'd26;
    localparam logic [CODE_W-1:0] ST_XOR   = 7'd27;
    localparam logic [CODE_W-1:0] ST_XORI  = 7'd28;
    localparam logic [CODE_W-1:0] ST_NOR   = 7'd29;
    localparam logic [CODE_W-1:0] ST_LUI   = 7'd30;
    localparam logic [CODE_W-1:0] ST_SLL   = 7'd31;
    localparam logic [CODE_W-1:0] ST_SRA   = 7'd32;
    localparam logic [CODE_W-1:0] ST_SRL   = 7'd33;
    localparam logic [CODE_W-1:0] ST_MOVN  = 7'd34;
    localparam logic [CODE_W-1:0] ST_MOVZ  = 7'd35;
    localparam logic [CODE_W-1:0] ST_BGEZ  = 7'd37;
    localparam logic [CODE_W-1:0] ST_BGTZ  = 7'd39;
    localparam logic [CODE_W-1:0] ST_BNE   = 7'd41;
    localparam logic [CODE_W-1:0] ST_BLEZ  = 7'd42;
    localparam logic [CODE_W-1:0] ST_JR    = 7'd44;
    localparam logic [CODE_W-1:0] ST_MFHI  = 7'd45;
    localparam logic [CODE_W-1:0] ST_MFLO  = 7'd46;
    localparam logic [CODE_W-1:0] ST_MTHI  = 7'd47;
    localparam logic [CODE_W-1:0] ST_MTLO  = 7'd48;
    localparam logic [CODE_W-1:0] ST_MULTU = 7'd49;
    localparam logic [CODE_W-1:0] ST_SD    = 7'd50;

    // Primary opcodes (instr[31:26])
    localparam logic [5:0] OP_SPECIAL  = 6'h00;
    localparam logic [5:0] OP_REGIMM   = 6'h01;
    localparam logic [5:0] OP_BEQ      = 6'h04;
    localparam logic [5:0] OP_BNE      = 6'h05;
    localparam logic [5:0] OP_BLEZ     = 6'h06;
    localparam logic [5:0] OP_BGTZ     = 6'h07;
    localparam logic [5:0] OP_ADDIU    = 6'h09;
    localparam logic [5:0] OP_SLTIU    = 6'h0B;
    localparam logic [5:0] OP_ANDI     = 6'h0C;
    localparam logic [5:0] OP_ORI      = 6'h0D;
    localparam logic [5:0] OP_XORI     = 6'h0E;
    localparam logic [5:0] OP_LUI      = 6'h0F;
    localparam logic [5:0] OP_SPECIAL2 = 6'h1C;
    localparam logic [5:0] OP_LB       = 6'h20;
    localparam logic [5:0] OP_LH       = 6'h21;
    localparam logic [5:0] OP_LW       = 6'h23;
    localparam logic [5:0] OP_LBU      = 6'h24;
    localparam logic [5:0] OP_LHU      = 6'h25;
    localparam logic [5:0] OP_SB       = 6'h28;
    localparam logic [5:0] OP_SH       = 6'h29;
    localparam logic [5:0] OP_SW       = 6'h2B;
    localparam logic [5:0] OP_SD       = 6'h3F;

    // SPECIAL funct codes (instr[5:0])
    localparam logic [5:0] FN_SLL   = 6'h00;
    localparam logic [5:0] FN_SRL   = 6'h02;
    localparam logic [5:0] FN_SRA   = 6'h03;
    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_MOVZ  = 6'h0A;
    localparam logic [5:0] FN_MOVN  = 6'h0B;
    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MTHI  = 6'h11;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MTLO  = 6'h13;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUBU  = 6'h23;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_XOR   = 6'h26;
    localparam logic [5:0] FN_NOR   = 6'h27;
    localparam logic [5:0] FN_SLTU  = 6'h2B;

    // SPECIAL2 funct codes
    localparam logic [5:0] FN2_CLZ  = 6'h20;
    localparam logic [5:0] FN2_CLO  = 6'h21;

    // REGIMM rt selector for BGEZ
    localparam logic [4:0] RT_BGEZ  = 5'b00001;

endpackage

// File: rtl/instr_decode_queue_if.sv
// Fetch-side and control-unit-side signals of the decode queue.
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; valid never waits on ready, and ready never depends
// combinationally on valid (in_ready comes from occupancy only).
interface instr_decode_queue_if #(
    parameter int STATE_W = 7,
    parameter int DEPTH   = 4
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic               in_valid;
    logic               in_ready;
    logic [31:0]        in_instr;
    logic               flush;
    logic               out_valid;
    logic               out_ready;
    logic [STATE_W-1:0] out_state;
    logic [31:0]        out_instr;
    logic               out_unknown;
    logic [CNT_W-1:0]   count;
    logic [15:0]        unknown_count;

    // Fetch and control unit together
    modport master (
        output in_valid, in_instr, flush, out_ready,
        input  in_ready, out_valid, out_state, out_instr, out_unknown,
               count, unknown_count
    );

    // The queue itself
    modport slave (
        input  in_valid, in_instr, flush, out_ready,
        output in_ready, out_valid, out_state, out_instr, out_unknown,
               count, unknown_count
    );
endinterface

// File: rtl/instr_decode_queue_state_decode.sv
// Combinational instruction -> control-unit start state decoder.
// First match wins; anything unmatched is flagged unknown with ST_SKIP.
module state_decode
    import instr_decode_queue_pkg::*;
#(
    parameter int STATE_W = 7
) (
    input  logic [31:0]        instr,
    output logic [STATE_W-1:0] state,
    output logic               unknown
);
    logic [5:0]        op;
    logic [5:0]        funct;
    logic [4:0]        rt;
    logic              special;
    logic [CODE_W-1:0] code;
    logic              unused_rs;

    assign op      = instr[31:26];
    assign funct   = instr[5:0];
    assign rt      = instr[20:16];
    assign special = (op == OP_SPECIAL);
    // The rs field never influences the start state.
    assign unused_rs = ^instr[25:21];

    // Priority decode of the opcode table
    always_comb begin
        code    = ST_SKIP;
        unknown = 1'b0;
        if      (special && funct == FN_ADDU)                          code = ST_ADDU;
        else if (special && funct == FN_SUBU)                          code = ST_SUBU;
        else if (op == OP_ADDIU)                                       code = ST_ADDIU;
        else if (special && funct == FN_MULTU && instr[15:6] == '0)    code = ST_MULTU;
        else if (special && funct == FN_SLTU)                          code = ST_SLTU;
        else if (op == OP_SLTIU)                                       code = ST_SLTIU;
        else if (op == OP_SPECIAL2 && funct == FN2_CLO)                code = ST_CLO;
        else if (op == OP_SPECIAL2 && funct == FN2_CLZ)                code = ST_CLZ;
        else if (special && funct == FN_AND)                           code = ST_AND;
        else if (op == OP_ANDI)                                        code = ST_ANDI;
        else if (special && funct == FN_OR)                            code = ST_OR;
        else if (op == OP_ORI)                                         code = ST_ORI;
        else if (special && funct == FN_XOR)                           code = ST_XOR;
        else if (op == OP_XORI)                                        code = ST_XORI;
        else if (special && funct == FN_NOR)                           code = ST_NOR;
        else if (op == OP_LUI)                                         code = ST_LUI;
        else if (special && funct == FN_SLL)                           code = ST_SLL;
        else if (special && funct == FN_SRA)                           code = ST_SRA;
        else if (special && funct == FN_SRL)                           code = ST_SRL;
        else if (special && funct == FN_MOVN)                          code = ST_MOVN;
        else if (special && funct == FN_MOVZ)                          code = ST_MOVZ;
        else if (special && funct == FN_MFHI)                          code = ST_MFHI;
        else if (special && funct == FN_MFLO)                          code = ST_MFLO;
        else if (special && funct == FN_MTHI)                          code = ST_MTHI;
        else if (special && funct == FN_MTLO)                          code = ST_MTLO;
        else if (op == OP_SB || op == OP_SH || op == OP_SW)            code = ST_STORE;
        else if (op == OP_SD)                                          code = ST_SD;
        else if (op == OP_BEQ)                                         code = ST_BEQ;
        else if (op == OP_REGIMM && rt == RT_BGEZ)                     code = ST_BGEZ;
        else if (op == OP_BGTZ && rt == '0)                            code = ST_BGTZ;
        else if (op == OP_BLEZ && rt == '0)                            code = ST_BLEZ;
        else if (op == OP_BNE)                                         code = ST_BNE;
        else if (special && funct == FN_JR && instr[20:11] == '0)      code = ST_JR;
        else if (op == OP_LW || op == OP_LH || op == OP_LHU ||
                 op == OP_LB || op == OP_LBU)                          code = ST_LOAD;
        else                                                           unknown = 1'b1;
    end

    assign state = STATE_W'(code);

endmodule

// File: rtl/instr_decode_queue.sv
// Decode queue between instruction fetch and the microcoded control unit.
// Each accepted instruction is decoded at enqueue and stored with its start
// state; unknown opcodes are dropped and counted (skip mode) or stored with
// TRAP_STATE and the unknown flag (trap mode). DEPTH must be a power of two
// so the pointers wrap naturally. Outputs come only from flops, so there is
// no combinational path from the in_* side to the out_* side.
module instr_decode_queue
    import instr_decode_queue_pkg::*;
#(
    parameter int STATE_W         = 7,
    parameter int DEPTH           = 4,
    parameter bit TRAP_ON_UNKNOWN = 1'b0,
    parameter int TRAP_STATE      = 63
) (
    input logic                  clk,
    input logic                  reset,
    instr_decode_queue_if.slave  q
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [31:0]        instr;
        logic [STATE_W-1:0] state;
        logic               unknown;
    } entry_t;

    entry_t             mem_q [DEPTH];
    entry_t             mem_d [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [15:0]        unk_cnt_q, unk_cnt_d;

    logic [STATE_W-1:0] dec_state;
    logic               dec_unknown;
    logic               accept;
    logic               push;
    logic               pop;
    entry_t             new_entry;
    entry_t             head;

    state_decode #(.STATE_W(STATE_W)) u_state_decode (
        .instr   (q.in_instr),
        .state   (dec_state),
        .unknown (dec_unknown)
    );

    // Full refuses input even when a pop happens this cycle (no pass-through).
    assign q.in_ready  = (count_q < CNT_W'(DEPTH));
    assign q.out_valid = (count_q != '0);

    // Handshake qualification, enqueue/dequeue and counter next-state
    always_comb begin
        accept = q.in_valid && q.in_ready && !q.flush;
        push   = accept && (!dec_unknown || TRAP_ON_UNKNOWN);
        pop    = q.out_valid && q.out_ready && !q.flush;

        new_entry.instr   = q.in_instr;
        new_entry.state   = dec_unknown ? STATE_W'(TRAP_STATE) : dec_state;
        new_entry.unknown = dec_unknown;

        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        unk_cnt_d = unk_cnt_q;

        if (q.flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = new_entry;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end

        // accept already excludes flush cycles
        if (accept && dec_unknown && unk_cnt_q != 16'hFFFF) begin
            unk_cnt_d = unk_cnt_q + 16'd1;
        end
    end

    // Queue storage, pointers and counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_q     <= '{default: '0};
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            unk_cnt_q <= '0;
        end else begin
            mem_q     <= mem_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            unk_cnt_q <= unk_cnt_d;
        end
    end

    // Head entry is masked to zero while the queue is empty.
    assign head            = mem_q[rd_ptr_q];
    assign q.out_state     = q.out_valid ? head.state   : '0;
    assign q.out_instr     = q.out_valid ? head.instr   : '0;
    assign q.out_unknown   = q.out_valid ? head.unknown : 1'b0;
    assign q.count         = count_q;
    assign q.unknown_count = unk_cnt_q;

endmodule
